sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
Parametrised serial-in/parallel-out deserializer, successor to the fixed 8-bit SIPO shift register. It collects WIDTH serial bits into a word, with selectable bit order and optional frame alignment. Each completed word is presented on a valid/ready output port with a holding register, and dropped words are flagged. It sits between a serial receive pin/PHY and byte- or word-oriented downstream logic.

Parameters:
WIDTH, 8, bits per parallel word (>=2)
MSB_FIRST, 1, 1 = first received bit lands in po_data[WIDTH-1]; 0 = first bit lands in po_data[0]
SYNC_MODE, 0, 0 = free-running word framing from reset; 1 = hunt for si_sync before assembling words
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low
si_valid  input  1  si_data is sampled this cycle
si_data  input  1  serial data bit
si_sync  input  1  frame start; qualified by si_valid, marks the current bit as bit 0 of a new word
po_data  output  WIDTH  assembled word (holding register)
po_valid  output  1  po_data holds an unconsumed word
po_ready  input  1  downstream accepts po_data when po_valid & po_ready
overrun  output  1  one-cycle pulse: completed word dropped because the holding register was full
bit_cnt  output  CNT_W  bits collected in the current partial word (0..WIDTH-1)
locked  output  1  1 when in SHIFT state

Behaviour:
- Reset (rst=0 at a clock edge): shift register=0, bit_cnt=0, po_data=0, po_valid=0, overrun=0. State is HUNT if SYNC_MODE=1, otherwise SHIFT. locked=0 in HUNT, 1 in SHIFT. Reset mid-word discards the partial word and any held word.
- FSM states:
  - HUNT: ignore si_data. si_valid & si_sync -> go to SHIFT; that bit is stored as bit 0 and bit_cnt=1.
  - SHIFT: only state used when SYNC_MODE=0, which never leaves it.
- Shifting (SHIFT, si_valid=1):
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], si_data}.
  - MSB_FIRST=0: sr <= {si_data, sr[WIDTH-1:1]}.
  - bit_cnt increments. si_valid=0 holds all state.
- si_sync while in SHIFT: the partial word is discarded silently (no overrun). The current bit becomes bit 0 and bit_cnt=1.
- Word completion: the edge at which the WIDTH-th bit is sampled. The completed word (including that bit) goes to the holding register if it is free or being consumed in the same cycle. po_valid=1 from the next cycle; latency is 1 clock from the last bit. bit_cnt returns to 0.
- Handshake:
  - po_data is stable while po_valid=1 and po_ready=0.
  - po_valid drops the cycle after acceptance unless a new word loads on that same edge.
  - po_ready is ignored while po_valid=0.
- Simultaneous completion and acceptance: the new word loads and po_valid stays 1 (back-to-back words, no bubble).
- Completion while po_valid=1 and po_ready=0: the new word is dropped and the held word is kept. overrun=1 for exactly one cycle and bit_cnt still wraps to 0.
- WIDTH=2 boundary: a word completes every second valid bit; the rules above are unchanged.

Decomposition:
- Package sipo_pkg:
  - state enum {HUNT, SHIFT};
  - function computing CNT_W;
  - constants MSB_FIRST_C/LSB_FIRST_C.
- Sub-module sipo_out_buf (WIDTH): a one-entry holding register with load/valid/ready. It reports load_ok back to the deserializer, and overrun is derived from load & !load_ok.
- The FSM, shifter and counter stay in sipo_deserializer.

Test Plan:
- Basic MSB-first: WIDTH=8, MSB_FIRST=1, SYNC_MODE=0, po_ready=1; after reset, send bits 1,0,1,0,0,1,0,1 on consecutive cycles -> po_data=8'hA5 with po_valid=1 for one cycle, starting the cycle after the 8th bit.
- Bit order: same stream 0,0,0,0,0,0,0,1 with MSB_FIRST=1 -> 8'h01; with MSB_FIRST=0 -> 8'h80.
- Gaps and sync: SYNC_MODE=1; send 5 bits without si_sync -> locked=0 and no output. Then si_sync on bit 1 of 8'hC3 with si_valid toggling 1/0 -> 8'hC3 emitted and locked=1. Next, si_sync after 3 bits of a word -> bit_cnt restarts at 1 and no overrun.
- Backpressure/overrun: po_ready=0; stream 8'h11 then 8'h22 -> po_data stays 8'h11, overrun pulses once when 8'h22 completes. Raise po_ready -> 8'h11 accepted, po_valid=0 next cycle.
- Back-to-back: po_ready=1 only on the 8'h33 completion edge while holding 8'h44 -> 8'h33 loaded on that edge and po_valid never drops.
- Reset mid-operation: rst=0 after 4 bits with a held word pending -> next cycle po_valid=0, po_data=0, bit_cnt=0. After reset, a fresh 8'h5A is received correctly.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
package sipo_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam bit MSB_FIRST_C = 1'b1;
  localparam bit LSB_FIRST_C = 1'b0;

  function automatic int calc_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register for completed words.
module sipo_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ok,
  output logic [WIDTH-1:0] po_data,
  output logic             po_valid,
  input  logic             po_ready
);

  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;

  // A load is accepted when the slot is empty or drains on this same edge.
  assign load_ok = !valid_reg || po_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (load && load_ok) begin
      data_reg  <= load_data;
      valid_reg <= 1'b1;
    end else if (valid_reg && po_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign po_data  = data_reg;
  assign po_valid = valid_reg;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with selectable bit order, optional
// frame hunting, and a valid/ready output holding register.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = MSB_FIRST_C,
  parameter bit SYNC_MODE = 1'b0,
  parameter int CNT_W     = calc_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si_valid,
  input  logic             si_data,
  input  logic             si_sync,
  output logic [WIDTH-1:0] po_data,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             locked
);

  localparam state_t RESET_STATE = SYNC_MODE ? HUNT : SHIFT;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sr_reg, sr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             overrun_reg;
  logic             load;
  logic             load_ok;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr, input logic d);
    if (MSB_FIRST == LSB_FIRST_C)
      return {d, sr[WIDTH-1:1]};
    else
      return {sr[WIDTH-2:0], d};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= RESET_STATE;
      sr_reg      <= '0;
      cnt_reg     <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sr_reg      <= sr_next;
      cnt_reg     <= cnt_next;
      overrun_reg <= load && !load_ok;
    end
  end

  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    if (si_valid) begin
      if (si_sync) begin
        // Frame start: any partial word is dropped and this bit becomes bit 0.
        state_next = SHIFT;
        sr_next    = shift_in('0, si_data);
        cnt_next   = CNT_W'(1);
      end else if (state_reg == SHIFT) begin
        sr_next = shift_in(sr_reg, si_data);
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          load     = 1'b1;
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  sipo_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(sr_next),
    .load_ok  (load_ok),
    .po_data  (po_data),
    .po_valid (po_valid),
    .po_ready (po_ready)
  );

  assign overrun = overrun_reg;
  assign bit_cnt = cnt_reg;
  assign locked  = (state_reg == SHIFT);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer: four instances share one serial
// stimulus stream (MSB-first, LSB-first, frame-hunting, and WIDTH=2).
module tb_sipo_deserializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic si_valid = 1'b0, si_data = 1'b0, si_sync = 1'b0, po_ready = 1'b0;

  logic [7:0] m_data, l_data, s_data;
  logic [1:0] w_data;
  logic       m_valid, l_valid, s_valid, w_valid;
  logic       m_ovr, l_ovr, s_ovr, w_ovr;
  logic [3:0] m_cnt, l_cnt, s_cnt;
  logic [1:0] w_cnt;
  logic       m_lock, l_lock, s_lock, w_lock;

  int compared = 0;
  int mismatched = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp;
  int  ovr_seen = 0;
  bit  watch_b2b = 0;
  bit  drop_seen = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1), .SYNC_MODE(1'b0)) dut (
    .clk(clk), .rst(rst), .si_valid(si_valid), .si_data(si_data), .si_sync(si_sync),
    .po_data(m_data), .po_valid(m_valid), .po_ready(po_ready), .overrun(m_ovr),
    .bit_cnt(m_cnt), .locked(m_lock));

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0), .SYNC_MODE(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .si_valid(si_valid), .si_data(si_data), .si_sync(si_sync),
    .po_data(l_data), .po_valid(l_valid), .po_ready(po_ready), .overrun(l_ovr),
    .bit_cnt(l_cnt), .locked(l_lock));

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1), .SYNC_MODE(1'b1)) dut_sync (
    .clk(clk), .rst(rst), .si_valid(si_valid), .si_data(si_data), .si_sync(si_sync),
    .po_data(s_data), .po_valid(s_valid), .po_ready(po_ready), .overrun(s_ovr),
    .bit_cnt(s_cnt), .locked(s_lock));

  sipo_deserializer #(.WIDTH(2), .MSB_FIRST(1'b1), .SYNC_MODE(1'b0)) dut_w2 (
    .clk(clk), .rst(rst), .si_valid(si_valid), .si_data(si_data), .si_sync(si_sync),
    .po_data(w_data), .po_valid(w_valid), .po_ready(po_ready), .overrun(w_ovr),
    .bit_cnt(w_cnt), .locked(w_lock));

  always @(negedge clk) begin
    if (m_ovr) ovr_seen++;
    if (watch_b2b && !m_valid) drop_seen = 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rev8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
  endfunction

  task automatic send_bit(input logic d, input logic sync);
    si_valid = 1'b1; si_data = d; si_sync = sync;
    @(posedge clk); #1;
    si_valid = 1'b0; si_sync = 1'b0;
  endtask

  // Stream w starting at w[7]; optional idle cycle between bits.
  task automatic send_word(input logic [7:0] w, input bit sync_first, input bit gap);
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i], sync_first && (i == 7));
      if (gap && i > 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
    compared++; if (m_data !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %h expected 00", m_data); end
    compared++; if (m_cnt !== 4'd0) begin mismatched++; $display("FAIL reset_cnt: got %0d expected 0", m_cnt); end
    compared++; if (m_ovr !== 1'b0) begin mismatched++; $display("FAIL reset_overrun: got %b expected 0", m_ovr); end
    compared++; if (m_lock !== 1'b1) begin mismatched++; $display("FAIL reset_locked_free: got %b expected 1", m_lock); end
    compared++; if (s_lock !== 1'b0) begin mismatched++; $display("FAIL reset_locked_sync: got %b expected 0", s_lock); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    po_ready = 1'b1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(rev8(8'hA5));
    send_word(8'hA5, 0, 0);
    @(negedge clk);
    compared++; if (m_valid !== 1'b1) begin mismatched++; $display("FAIL basic_valid: got %b expected 1", m_valid); end
    exp = exp_q.pop_front();
    compared++; if (m_data !== exp) begin mismatched++; $display("FAIL basic_data: got %h expected %h", m_data, exp); end
    exp = exp_q.pop_front();
    compared++; if (l_data !== exp) begin mismatched++; $display("FAIL basic_lsb_data: got %h expected %h", l_data, exp); end
    $display("basic: msb word %h lsb word %h", m_data, l_data);
    @(posedge clk); @(negedge clk);
    compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL basic_one_cycle: got %b expected 0", m_valid); end
  endtask

  task automatic test_bit_order();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    send_word(8'h01, 0, 0);
    @(negedge clk);
    exp = exp_q.pop_front();
    compared++; if (m_data !== exp || m_valid !== 1'b1) begin mismatched++; $display("FAIL order_msb: got %h/%b expected %h/1", m_data, m_valid, exp); end
    exp = exp_q.pop_front();
    compared++; if (l_data !== exp || l_valid !== 1'b1) begin mismatched++; $display("FAIL order_lsb: got %h/%b expected %h/1", l_data, l_valid, exp); end
    $display("order: msb word %h lsb word %h", m_data, l_data);
  endtask

  task automatic test_sync();
    do_reset();
    po_ready = 1'b1;
    send_word(8'b11011000, 0, 0);  // only first 5 bits matter below
    @(negedge clk);
    compared++; if (s_lock !== 1'b0 || s_valid !== 1'b0) begin mismatched++; $display("FAIL hunt_idle: got lock %b valid %b expected 0/0", s_lock, s_valid); end
    compared++; if (s_cnt !== 4'd0) begin mismatched++; $display("FAIL hunt_cnt: got %0d expected 0", s_cnt); end
    exp_q.push_back(8'hC3);
    send_word(8'hC3, 1, 1);
    @(negedge clk);
    exp = exp_q.pop_front();
    compared++; if (s_data !== exp || s_valid !== 1'b1) begin mismatched++; $display("FAIL sync_word: got %h/%b expected %h/1", s_data, s_valid, exp); end
    compared++; if (s_lock !== 1'b1) begin mismatched++; $display("FAIL sync_locked: got %b expected 1", s_lock); end
    $display("sync: word %h", s_data);
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    exp_q.push_back(8'hB4);
    send_bit(1'b1, 1);
    @(negedge clk);
    compared++; if (s_cnt !== 4'd1 || m_cnt !== 4'd1) begin mismatched++; $display("FAIL resync_cnt: got %0d/%0d expected 1/1", s_cnt, m_cnt); end
    compared++; if (s_ovr !== 1'b0 || m_ovr !== 1'b0) begin mismatched++; $display("FAIL resync_overrun: got %b/%b expected 0/0", s_ovr, m_ovr); end
    for (int i = 6; i >= 0; i--) send_bit(exp_q[0][i], 0);
    @(negedge clk);
    exp = exp_q.pop_front();
    compared++; if (s_data !== exp || s_valid !== 1'b1 || s_ovr !== 1'b0) begin mismatched++; $display("FAIL resync_word: got %h/%b/%b expected %h/1/0", s_data, s_valid, s_ovr, exp); end
    $display("resync: word %h", s_data);
  endtask

  task automatic test_overrun();
    do_reset();
    po_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_word(8'h11, 0, 0);
    ovr_seen = 0;
    send_word(8'h22, 0, 0);
    @(negedge clk);
    compared++; if (m_ovr !== 1'b1) begin mismatched++; $display("FAIL ovr_pulse: got %b expected 1", m_ovr); end
    compared++; if (m_data !== exp_q[0]) begin mismatched++; $display("FAIL ovr_hold: got %h expected %h", m_data, exp_q[0]); end
    compared++; if (m_cnt !== 4'd0) begin mismatched++; $display("FAIL ovr_cnt: got %0d expected 0", m_cnt); end
    @(posedge clk); #1;
    po_ready = 1'b1;
    @(negedge clk);
    compared++; if (m_ovr !== 1'b0) begin mismatched++; $display("FAIL ovr_width: got %b expected 0", m_ovr); end
    exp = exp_q.pop_front();
    compared++; if (m_data !== exp || m_valid !== 1'b1) begin mismatched++; $display("FAIL ovr_accept: got %h/%b expected %h/1", m_data, m_valid, exp); end
    $display("overrun: accepted word %h", m_data);
    @(posedge clk); @(negedge clk);
    compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL ovr_drain: got %b expected 0", m_valid); end
    compared++; if (ovr_seen != 1) begin mismatched++; $display("FAIL ovr_count: got %0d expected 1", ovr_seen); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    po_ready = 1'b0;
    exp_q.push_back(8'h44);
    send_word(8'h44, 0, 0);
    drop_seen = 0;
    watch_b2b = 1;
    exp_q.push_back(8'h33);
    for (int i = 7; i >= 1; i--) send_bit(exp_q[1][i], 0);
    si_valid = 1'b1; si_data = exp_q[1][0]; po_ready = 1'b1;
    @(negedge clk);
    exp = exp_q.pop_front();
    compared++; if (m_data !== exp) begin mismatched++; $display("FAIL b2b_first: got %h expected %h", m_data, exp); end
    @(posedge clk); #1;
    si_valid = 1'b0; po_ready = 1'b0;
    @(negedge clk);
    exp = exp_q.pop_front();
    compared++; if (m_data !== exp || m_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_second: got %h/%b expected %h/1", m_data, m_valid, exp); end
    compared++; if (m_ovr !== 1'b0) begin mismatched++; $display("FAIL b2b_overrun: got %b expected 0", m_ovr); end
    watch_b2b = 0;
    compared++; if (drop_seen !== 1'b0) begin mismatched++; $display("FAIL b2b_bubble: got %b expected 0", drop_seen); end
    $display("back_to_back: held word %h", m_data);
  endtask

  task automatic test_reset_mid();
    do_reset();
    po_ready = 1'b0;
    send_word(8'h77, 0, 0);
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    compared++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin mismatched++; $display("FAIL midrst_out: got %h/%b expected 00/0", m_data, m_valid); end
    compared++; if (m_cnt !== 4'd0) begin mismatched++; $display("FAIL midrst_cnt: got %0d expected 0", m_cnt); end
    rst = 1'b1;
    exp_q.delete();
    po_ready = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(8'h5A);
    send_word(8'h5A, 0, 0);
    @(negedge clk);
    exp = exp_q.pop_front();
    compared++; if (m_data !== exp || m_valid !== 1'b1) begin mismatched++; $display("FAIL midrst_fresh: got %h/%b expected %h/1", m_data, m_valid, exp); end
    $display("reset_mid: fresh word %h", m_data);
  endtask

  task automatic test_width2();
    do_reset();
    po_ready = 1'b1;
    send_bit(1'b1, 0);
    @(negedge clk);
    compared++; if (w_cnt !== 2'd1 || w_valid !== 1'b0) begin mismatched++; $display("FAIL w2_partial: got cnt %0d valid %b expected 1/0", w_cnt, w_valid); end
    exp_q.push_back(8'h02);
    send_bit(1'b0, 0);
    @(negedge clk);
    exp = exp_q.pop_front();
    compared++; if ({6'b0, w_data} !== exp || w_valid !== 1'b1 || w_cnt !== 2'd0) begin mismatched++; $display("FAIL w2_word1: got %h/%b cnt %0d expected %h/1 cnt 0", w_data, w_valid, w_cnt, exp); end
    exp_q.push_back(8'h03);
    send_bit(1'b1, 0); send_bit(1'b1, 0);
    @(negedge clk);
    exp = exp_q.pop_front();
    compared++; if ({6'b0, w_data} !== exp || w_valid !== 1'b1) begin mismatched++; $display("FAIL w2_word2: got %h/%b expected %h/1", w_data, w_valid, exp); end
    $display("width2: word %b", w_data);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bit_order();
    test_sync();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_width2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
